// File: rtl/data_unpacker_pkg.sv
// Shared sizing helpers and state encoding for the packer/unpacker width converters.
package data_unpacker_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } unpack_state_e;

  function automatic int ceil_a_by_b(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Counter width for n beats; never narrower than one bit.
  function automatic int c_log_2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/data_packer.sv
// Narrow-to-wide packer: gathers ceil(OUT/IN) beats, first beat in the LSBs, into one word.
module data_packer
  import data_unpacker_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_write_req,
  output logic                 s_write_ready,
  input  logic [IN_WIDTH-1:0]  s_write_data,
  output logic                 m_write_req,
  input  logic                 m_write_ready,
  output logic [OUT_WIDTH-1:0] m_write_data
);

  localparam int NUM_BEATS = ceil_a_by_b(OUT_WIDTH, IN_WIDTH);
  localparam int CNT_W     = c_log_2(NUM_BEATS);
  localparam int ACC_W     = NUM_BEATS * IN_WIDTH;

  logic [ACC_W-1:0]     acc_q, acc_d, acc_shift;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] word_q, word_d;
  logic                 vld_q, vld_d;
  logic                 s_fire, m_fire, fill_last;

  assign s_write_ready = !vld_q || m_write_ready;
  assign s_fire        = s_write_req && s_write_ready;
  assign m_fire        = vld_q && m_write_ready;
  assign fill_last     = (cnt_q == CNT_W'(NUM_BEATS - 1));
  assign m_write_req   = vld_q;
  assign m_write_data  = word_q;

  // New beat enters at the top; after NUM_BEATS shifts beat 0 sits in the LSBs.
  assign acc_shift = (acc_q >> IN_WIDTH) | (ACC_W'(s_write_data) << (ACC_W - IN_WIDTH));

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    word_d = word_q;
    vld_d  = vld_q;
    if (m_fire) vld_d = 1'b0;
    if (s_fire) begin
      acc_d = acc_shift;
      if (fill_last) begin
        word_d = acc_shift[OUT_WIDTH-1:0];
        vld_d  = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: rtl/data_unpacker.sv
// Wide-to-narrow unpacker: one IN_WIDTH word out as ceil(IN/OUT) beats, LSB slice first.
module data_unpacker
  import data_unpacker_pkg::*;
#(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 64,
  parameter int OP_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_write_req,
  output logic                 s_write_ready,
  input  logic [IN_WIDTH-1:0]  s_write_data,
  output logic                 m_write_req,
  input  logic                 m_write_ready,
  output logic [OUT_WIDTH-1:0] m_write_data,
  output logic                 m_write_last
);

  localparam int NUM_BEATS = ceil_a_by_b(IN_WIDTH, OUT_WIDTH);
  localparam int CNT_W     = c_log_2(NUM_BEATS);
  localparam int SREG_W    = NUM_BEATS * OUT_WIDTH;

  if ((IN_WIDTH % OP_WIDTH) != 0 || (OUT_WIDTH % OP_WIDTH) != 0) begin : g_bad_op_width
    $error("data_unpacker: IN_WIDTH and OUT_WIDTH must be multiples of OP_WIDTH");
  end

  unpack_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SREG_W-1:0] sreg_q, sreg_d;
  logic              s_fire, m_fire;

  assign m_write_req   = (state_q == SEND);
  assign m_write_last  = (state_q == SEND) && (cnt_q == CNT_W'(NUM_BEATS - 1));
  assign m_write_data  = sreg_q[OUT_WIDTH-1:0];
  // Ready while the last beat leaves lets the next word load with no bubble.
  assign s_write_ready = (state_q == IDLE) || (m_write_last && m_write_ready);
  assign s_fire        = s_write_req && s_write_ready;
  assign m_fire        = m_write_req && m_write_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      IDLE: begin
        if (s_fire) begin
          sreg_d  = SREG_W'(s_write_data);
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_fire) begin
          if (!m_write_last) begin
            sreg_d = sreg_q >> OUT_WIDTH;
            cnt_d  = cnt_q + CNT_W'(1);
          end else if (s_fire) begin
            sreg_d = SREG_W'(s_write_data);
            cnt_d  = '0;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

endmodule

// File: tb/tb_data_unpacker.sv
// Directed + randomized bench for data_unpacker (128->64, 96->64) and a packer->unpacker loopback.
module tb_data_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 128 -> 64
  logic         a_s_req = 0, a_s_rdy, a_m_req, a_m_rdy = 0, a_m_last;
  logic [127:0] a_s_data = '0;
  logic [63:0]  a_m_data;
  data_unpacker #(.IN_WIDTH(128), .OUT_WIDTH(64), .OP_WIDTH(16)) u_dut (
    .clk(clk), .reset(rst_n),
    .s_write_req(a_s_req), .s_write_ready(a_s_rdy), .s_write_data(a_s_data),
    .m_write_req(a_m_req), .m_write_ready(a_m_rdy), .m_write_data(a_m_data),
    .m_write_last(a_m_last));

  // 96 -> 64, short final beat
  logic        b_s_req = 0, b_s_rdy, b_m_req, b_m_rdy = 0, b_m_last;
  logic [95:0] b_s_data = '0;
  logic [63:0] b_m_data;
  data_unpacker #(.IN_WIDTH(96), .OUT_WIDTH(64), .OP_WIDTH(16)) u_dut96 (
    .clk(clk), .reset(rst_n),
    .s_write_req(b_s_req), .s_write_ready(b_s_rdy), .s_write_data(b_s_data),
    .m_write_req(b_m_req), .m_write_ready(b_m_rdy), .m_write_data(b_m_data),
    .m_write_last(b_m_last));

  // loopback: packer 64->128 then unpacker 128->64
  logic         p_s_req = 0, p_s_rdy, w_req, w_rdy, l_m_req, l_m_rdy = 0, l_m_last;
  logic [63:0]  p_s_data = '0, l_m_data;
  logic [127:0] w_data;
  data_packer #(.IN_WIDTH(64), .OUT_WIDTH(128)) u_lb_pk (
    .clk(clk), .reset(rst_n),
    .s_write_req(p_s_req), .s_write_ready(p_s_rdy), .s_write_data(p_s_data),
    .m_write_req(w_req), .m_write_ready(w_rdy), .m_write_data(w_data));
  data_unpacker #(.IN_WIDTH(128), .OUT_WIDTH(64), .OP_WIDTH(16)) u_lb_unp (
    .clk(clk), .reset(rst_n),
    .s_write_req(w_req), .s_write_ready(w_rdy), .s_write_data(w_data),
    .m_write_req(l_m_req), .m_write_ready(l_m_rdy), .m_write_data(l_m_data),
    .m_write_last(l_m_last));

  // Reference model: each accepted word becomes a queue of {last, slice} beats.
  logic [64:0] qa[$], qb[$], ql[$];
  int          lb_in = 0;

  always @(negedge clk) begin
    if (!rst_n) qa.delete();
    else begin
      chk("a_req", a_m_req, qa.size() != 0);
      chk("a_srdy", a_s_rdy, (qa.size() == 0) || (qa.size() == 1 && a_m_rdy));
      if (!a_m_req) chk("a_last_idle", a_m_last, 0);
      if (a_m_req && qa.size() != 0) begin
        chk("a_beat", {a_m_last, a_m_data}, qa[0]);
        if (a_m_rdy) void'(qa.pop_front());
      end
      if (a_s_req && a_s_rdy)
        for (int i = 0; i < 2; i++) qa.push_back({i == 1, 64'(a_s_data >> (64 * i))});
    end
  end

  always @(negedge clk) begin
    if (!rst_n) qb.delete();
    else begin
      chk("b_req", b_m_req, qb.size() != 0);
      chk("b_srdy", b_s_rdy, (qb.size() == 0) || (qb.size() == 1 && b_m_rdy));
      if (b_m_req && qb.size() != 0) begin
        chk("b_beat", {b_m_last, b_m_data}, qb[0]);
        if (b_m_rdy) void'(qb.pop_front());
      end
      if (b_s_req && b_s_rdy)
        for (int i = 0; i < 2; i++) qb.push_back({i == 1, 64'(b_s_data >> (64 * i))});
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      ql.delete();
      lb_in = 0;
    end else begin
      if (l_m_req) begin
        chk("lb_pending", ql.size() != 0, 1);
        if (ql.size() != 0) begin
          chk("lb_beat", {l_m_last, l_m_data}, ql[0]);
          if (l_m_rdy) void'(ql.pop_front());
        end
      end
      if (p_s_req && p_s_rdy) begin
        ql.push_back({1'(lb_in % 2), p_s_data});
        lb_in++;
      end
    end
  end

  localparam logic [127:0] W  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [63:0]  WL = 64'h5555_6666_7777_8888;
  localparam logic [63:0]  WH = 64'h1111_2222_3333_4444;

  initial begin
    int  nw;
    bit  fired;
    logic [127:0] wa, wb;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_srdy", a_s_rdy, 1);
    chk("rst_req", a_m_req, 0);
    chk("rst_last", a_m_last, 0);
    chk("rst_data", a_m_data, 0);

    // single word
    step(); a_s_req = 1; a_s_data = W; a_m_rdy = 1;
    @(negedge clk); chk("t1_srdy_idle", a_s_rdy, 1); chk("t1_req0", a_m_req, 0);
    step(); a_s_req = 0; a_s_data = '1;
    @(negedge clk); chk("t1_b0", {a_m_req, a_m_last, a_m_data}, {2'b10, WL}); chk("t1_srdy_busy", a_s_rdy, 0);
    step();
    @(negedge clk); chk("t1_b1", {a_m_req, a_m_last, a_m_data}, {2'b11, WH}); chk("t1_srdy_last", a_s_rdy, 1);
    step();
    @(negedge clk); chk("t1_done", a_m_req, 0);

    // backpressure, with junk presented while not ready
    step(); a_s_req = 1; a_s_data = W; a_m_rdy = 0;
    step(); a_s_data = ~W;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_hold", {a_m_req, a_m_last, a_m_data}, {2'b10, WL});
      chk("t2_srdy", a_s_rdy, 0);
      if (k < 2) step();
    end
    step(); a_s_req = 0; a_m_rdy = 1;
    @(negedge clk); chk("t2_b0", a_m_data, WL);
    step();
    @(negedge clk); chk("t2_b1", {a_m_last, a_m_data}, {1'b1, WH});
    step();
    @(negedge clk); chk("t2_done", a_m_req, 0);

    // back-to-back words
    wa = {$urandom, $urandom, $urandom, $urandom};
    wb = {$urandom, $urandom, $urandom, $urandom};
    step(); a_s_req = 1; a_s_data = wa; a_m_rdy = 1;
    @(negedge clk);
    step(); a_s_data = wb;
    @(negedge clk); chk("t3_a0", a_m_data, wa[63:0]); chk("t3_srdy_a0", a_s_rdy, 0);
    step();
    @(negedge clk); chk("t3_a1", {a_m_last, a_m_data}, {1'b1, wa[127:64]}); chk("t3_srdy_a1", a_s_rdy, 1);
    step(); a_s_req = 0;
    @(negedge clk); chk("t3_b0", {a_m_req, a_m_data}, {1'b1, wb[63:0]}); chk("t3_srdy_b0", a_s_rdy, 0);
    step();
    @(negedge clk); chk("t3_b1", {a_m_last, a_m_data}, {1'b1, wb[127:64]});
    step();
    @(negedge clk); chk("t3_done", a_m_req, 0);

    // 96 -> 64 zero-padded final beat
    step(); b_s_req = 1; b_s_data = 96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF; b_m_rdy = 1;
    step(); b_s_req = 0;
    @(negedge clk); chk("t4_b0", {b_m_last, b_m_data}, {1'b0, 64'hCCCC_DDDD_EEEE_FFFF});
    step();
    @(negedge clk); chk("t4_b1", {b_m_last, b_m_data}, {1'b1, 64'h0000_0000_AAAA_BBBB});
    step();
    @(negedge clk); chk("t4_done", b_m_req, 0);

    // reset after beat 0 accepted
    step(); a_s_req = 1; a_s_data = W; a_m_rdy = 1;
    step(); a_s_req = 0;
    @(negedge clk); chk("t5_b0", a_m_data, WL);
    step(); rst_n = 0;
    step(); rst_n = 1;
    @(negedge clk);
    chk("t5_req", a_m_req, 0); chk("t5_data", a_m_data, 0); chk("t5_srdy", a_s_rdy, 1);
    step();
    @(negedge clk); chk("t5_nobeat", a_m_req, 0);

    // randomized traffic on the 128->64 unit
    nw = 0;
    for (int c = 0; c < 6000 && nw < 200; c++) begin
      @(negedge clk);
      fired = a_s_req && a_s_rdy;
      if (fired) nw++;
      step();
      if (fired || !a_s_req) a_s_req = ($urandom_range(3) != 0);
      a_s_data = {$urandom, $urandom, $urandom, $urandom};
      a_m_rdy  = ($urandom_range(2) != 0);
    end
    a_s_req = 0;
    chk("rand_words", nw, 200);
    a_m_rdy = 1;
    for (int c = 0; c < 20 && qa.size() != 0; c++) @(negedge clk);
    chk("rand_drain", qa.size(), 0);

    // loopback 1000 beats
    nw = 0;
    for (int c = 0; c < 10000 && nw < 1000; c++) begin
      @(negedge clk);
      fired = p_s_req && p_s_rdy;
      if (fired) nw++;
      step();
      if (fired || !p_s_req) p_s_req = ($urandom_range(4) != 0);
      p_s_data = {$urandom, $urandom};
      l_m_rdy  = ($urandom_range(2) != 0);
    end
    p_s_req = 0;
    chk("lb_in_count", nw, 1000);
    l_m_rdy = 1;
    for (int c = 0; c < 50 && ql.size() != 0; c++) @(negedge clk);
    chk("lb_drain", ql.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
